// File: rtl/keypad_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_timer_ctrl
//  Purpose  : Debounced 10-key BCD keypad front end with a shifting digit
//             entry buffer, plus a run-mode tick divider (pgt_1Hz).
//  Ports    : clk        - system clock, all state on its rising edge
//             clear      - synchronous active-high reset
//             keyboard   - raw key lines (bit k = key "k"), asynchronous
//             enablen    - 1 = entry mode (keys accepted, divider held)
//                          0 = run mode (divider ticking, keys ignored)
//             d          - BCD code of the last accepted key
//             loadn      - active-low one-cycle accepted-key strobe
//             key_valid  - active-high copy of the strobe
//             digits     - entry buffer, digit 0 (bits 3:0) is newest
//             pgt_1Hz    - one-cycle tick every CLK_DIV cycles in run mode
//  Options  : define KEY_REPEAT_EN to re-issue the strobe every
//             REPEAT_CYCLES cycles while a key stays held in entry mode.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_timer_ctrl #(
    parameter int CLK_DIV         = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int DIGITS          = 4,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [9:0]          keyboard,
    input  logic                enablen,
    output logic [3:0]          d,
    output logic                loadn,
    output logic                key_valid,
    output logic [4*DIGITS-1:0] digits,
    output logic                pgt_1Hz
);

    localparam int c_DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int c_DIV_W = $clog2(CLK_DIV) + 1;

    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_DEB_PRESS   = 2'd1;
    localparam logic [1:0] c_HELD        = 2'd2;
    localparam logic [1:0] c_DEB_RELEASE = 2'd3;

    generate
        if (CLK_DIV < 2 || DEBOUNCE_CYCLES < 1 || DIGITS < 1 || DIGITS > 8 ||
            REPEAT_CYCLES < 1) begin : g_param_check
            $error("keypad_timer_ctrl: parameter out of legal range");
        end
    endgenerate

    logic [9:0]          sync1_q, sync2_q;
    logic [1:0]          state_q, state_d;
    logic [c_DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]          cand_q, cand_d;
    logic [3:0]          d_q, d_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic                key_valid_q, key_valid_d;
    logic [c_DIV_W-1:0]  div_q, div_d;

    logic [3:0]          key_code;
    logic                key_any;
    logic                strobe;

`ifdef KEY_REPEAT_EN
    localparam int c_REP_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);
    logic [c_REP_W-1:0]  rep_cnt_q, rep_cnt_d;
`endif

    // Priority encoder: ascending scan so the highest active line wins.
    always_comb begin
        key_code = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (sync2_q[k]) begin
                key_code = 4'(k);
            end
        end
    end

    assign key_any = |sync2_q;

    // Key debounce FSM. The counter holds the number of consecutive
    // qualifying samples seen so far, so a transition fires on the sample
    // that brings it to DEBOUNCE_CYCLES.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        cand_d    = cand_q;
        strobe    = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (key_any) begin
                    state_d   = c_DEB_PRESS;
                    deb_cnt_d = c_DEB_ONE;
                    cand_d    = key_code;
                end
            end
            c_DEB_PRESS: begin
                if (!key_any || key_code != cand_q) begin
                    state_d   = c_IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= c_DEB_LAST) begin
                    state_d   = c_HELD;
                    deb_cnt_d = '0;
                    strobe    = 1'b1;
`ifdef KEY_REPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            c_HELD: begin
                if (!key_any) begin
                    state_d   = c_DEB_RELEASE;
                    deb_cnt_d = c_DEB_ONE;
                end
`ifdef KEY_REPEAT_EN
                // Repeat interval restarts from each strobe and only runs
                // while entry mode is active.
                else if (enablen) begin
                    if (rep_cnt_q >= c_REP_LAST) begin
                        strobe    = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end else begin
                    rep_cnt_d = '0;
                end
`endif
            end
            c_DEB_RELEASE: begin
                if (key_any) begin
                    state_d   = c_HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= c_DEB_LAST) begin
                    state_d   = c_IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = c_IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    // Accepted-key outputs: only entry mode lets a strobe reach the buffer.
    always_comb begin
        d_d         = d_q;
        digits_d    = digits_q;
        key_valid_d = 1'b0;
        if (strobe && enablen) begin
            d_d         = cand_q;
            digits_d    = (digits_q << 4) | (4*DIGITS)'(cand_q);
            key_valid_d = 1'b1;
        end
    end

    // Tick divider: held at zero in entry mode, wraps at CLK_DIV-1.
    always_comb begin
        if (enablen || div_q == c_DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= c_IDLE;
            deb_cnt_q   <= '0;
            cand_q      <= '0;
            d_q         <= '0;
            digits_q    <= '0;
            key_valid_q <= 1'b0;
            div_q       <= '0;
        end else begin
            sync1_q     <= keyboard;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            cand_q      <= cand_d;
            d_q         <= d_d;
            digits_q    <= digits_d;
            key_valid_q <= key_valid_d;
            div_q       <= div_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign d         = d_q;
    assign key_valid = key_valid_q;
    assign loadn     = ~key_valid_q;
    assign digits    = digits_q;
    assign pgt_1Hz   = (div_q == c_DIV_LAST);

endmodule
`default_nettype wire

// File: tb/tb_keypad_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_timer_ctrl
//  Purpose  : Self-checking bench for keypad_timer_ctrl. A run-length model
//             of the key acceptance rules and a modulo model of the divider
//             are compared to the DUT after every clock; directed scenarios
//             add hand-computed expectations. Honours KEY_REPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_timer_ctrl;

    localparam int CLK_DIV = 10;
    localparam int DEB     = 4;
    localparam int DIGITS  = 4;
    localparam int REP     = 8;
`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clear;
    logic        enablen;
    logic [9:0]  keyboard;
    logic [3:0]  d;
    logic        loadn;
    logic        key_valid;
    logic [15:0] digits;
    logic        pgt_1Hz;

    keypad_timer_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_CYCLES(DEB),
        .DIGITS         (DIGITS),
        .REPEAT_CYCLES  (REP)
    ) u_dut (
        .clk      (clk),
        .clear    (clear),
        .keyboard (keyboard),
        .enablen  (enablen),
        .d        (d),
        .loadn    (loadn),
        .key_valid(key_valid),
        .digits   (digits),
        .pgt_1Hz  (pgt_1Hz)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int strobe_q[$];
    int tick_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [9:0] mask(input int k);
        logic [9:0] one = 10'd1;
        return one << k;
    endfunction

    function automatic int top_key(input logic [9:0] s);
        for (int k = 9; k >= 0; k--) if (s[k]) return k;
        return 0;
    endfunction

    // ---------------- behavioural model ----------------
    logic [9:0]  m_k1, m_k2;      // raw samples one and two edges ago
    bit          m_armed;         // released long enough to accept a new press
    int          m_run;           // consecutive samples of the same pressed code
    int          m_cur;           // code being qualified / held
    int          m_zrun;          // consecutive zero samples while held
    int          m_rep;           // held samples since last strobe
    logic [3:0]  m_d;
    logic [15:0] m_digits;
    bit          m_kv;
    int          m_div;           // run-mode edges since stop, modulo CLK_DIV

    task automatic model_step();
        logic [9:0] s;
        int  code;
        bit  nz;
        bit  fire;
        if (clear) begin
            m_k1 = '0; m_k2 = '0; m_armed = 1'b1; m_run = 0; m_cur = 0;
            m_zrun = 0; m_rep = 0; m_d = '0; m_digits = '0; m_kv = 1'b0; m_div = 0;
            return;
        end
        s    = m_k2;
        m_k2 = m_k1;
        m_k1 = keyboard;
        nz   = (s != 10'd0);
        code = top_key(s);
        fire = 1'b0;
        m_kv = 1'b0;
        if (m_armed) begin
            if (!nz) m_run = 0;
            else if (m_run > 0 && code != m_cur) m_run = 0;
            else begin
                if (m_run == 0) m_cur = code;
                m_run++;
                if (m_run == DEB) begin
                    fire = 1'b1; m_armed = 1'b0; m_run = 0; m_zrun = 0; m_rep = 0;
                end
            end
        end else begin
            if (!nz) begin
                m_zrun++;
                if (m_zrun == DEB) m_armed = 1'b1;
            end else if (m_zrun > 0) begin
                m_zrun = 0;
            end else if (REPEAT_ON) begin
                if (enablen) begin
                    m_rep++;
                    if (m_rep == REP) begin fire = 1'b1; m_rep = 0; end
                end else m_rep = 0;
            end
        end
        if (fire && enablen) begin
            m_kv     = 1'b1;
            m_d      = 4'(m_cur);
            m_digits = {m_digits[11:0], 4'(m_cur)};
        end
        m_div = enablen ? 0 : (m_div + 1) % CLK_DIV;
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            check("d",         d,         m_d);
            check("loadn",     loadn,     !m_kv);
            check("key_valid", key_valid, m_kv);
            check("digits",    digits,    m_digits);
            check("pgt_1Hz",   pgt_1Hz,   (m_div == CLK_DIV - 1));
            if (key_valid === 1'b1) strobe_q.push_back(cyc);
            if (pgt_1Hz === 1'b1)   tick_q.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [9:0] k, input int hold, input int gap);
        keyboard = k;
        idle(hold);
        keyboard = '0;
        idle(gap);
    endtask

    function automatic int first_strobe();
        return (strobe_q.size() > 0) ? strobe_q[0] : -1000;
    endfunction

    initial begin
        int a;
        int r;
        int keys[5] = '{1, 2, 3, 4, 9};
        clear    = 1'b1;
        enablen  = 1'b1;
        keyboard = '0;
        idle(3);
        check("reset_d",         d,         4'h0);
        check("reset_loadn",     loadn,     1'b1);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_digits",    digits,    16'h0000);
        check("reset_pgt",       pgt_1Hz,   1'b0);
        clear = 1'b0;
        idle(2);

        // Single press of key 5: strobe DEB cycles after the synchronized rise.
        strobe_q.delete();
        a = cyc;
        press(mask(5), 20, 10);
        check("key5_strobes",  strobe_q.size(), 1);
        check("key5_latency",  first_strobe() - (a + 2), DEB);
        check("key5_d",        d,      4'h5);
        check("key5_digits",   digits, 16'h0005);

        // Digit entry sequence.
        strobe_q.delete();
        foreach (keys[i]) press(mask(keys[i]), 8, 10);
        check("seq_strobes", strobe_q.size(), 5);
        check("seq_d",       d,      4'h9);
        check("seq_digits",  digits, 16'h2349);

        // Bounce: 3 high, 1 low, 6 high.
        strobe_q.delete();
        keyboard = mask(7); idle(3);
        keyboard = '0;      idle(1);
        a = cyc;
        keyboard = mask(7); idle(6);
        keyboard = '0;      idle(10);
        check("bounce_strobes", strobe_q.size(), 1);
        check("bounce_latency", first_strobe() - (a + 2), DEB);
        strobe_q.delete();
        press(mask(7), 2, 10);
        check("glitch_strobes", strobe_q.size(), 0);

        // Two keys together and a run-mode press.
        press(mask(2) | mask(8), 8, 10);
        check("priority_d",      d,      4'h8);
        check("priority_digits", digits, 16'h4978);
        strobe_q.delete();
        enablen = 1'b0;
        press(mask(3), 8, 10);
        check("runmode_strobes", strobe_q.size(), 0);
        check("runmode_digits",  digits, 16'h4978);
        check("runmode_d",       d,      4'h8);
        enablen = 1'b1;
        idle(2);

        // Divider: ticks on the 10th, 20th, 30th run-mode cycle.
        tick_q.delete();
        a = cyc;
        enablen = 1'b0;
        idle(35);
        enablen = 1'b1;
        check("tick_count", tick_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("tick_cycle", (tick_q.size() > i) ? tick_q[i] - a + 1 : -1, 10 * (i + 1));
        tick_q.delete();
        idle(20);
        check("entry_ticks", tick_q.size(), 0);
        enablen = 1'b0;
        idle(5);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        r = cyc;
        tick_q.delete();
        idle(12);
        enablen = 1'b1;
        check("clear_tick_count", tick_q.size(), 1);
        check("clear_tick_cycle", (tick_q.size() > 0) ? tick_q[0] - r + 1 : -1, 10);
        idle(2);

        // Clear lands on the strobe edge: key re-debounced from scratch.
        strobe_q.delete();
        a = cyc;
        keyboard = mask(3);
        idle(5);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        idle(12);
        keyboard = '0;
        idle(10);
        check("clear_strobe_count", strobe_q.size(), 1);
        check("clear_strobe_cycle", first_strobe() - a, 12);
        check("clear_strobe_digits", digits, 16'h0003);

        // Held key: auto-repeat only with the option enabled.
        strobe_q.delete();
        a = cyc;
        press(mask(6), 30, 10);
        check("hold_strobes", strobe_q.size(), REPEAT_ON ? 4 : 1);
        check("hold_first",   first_strobe() - (a + 2), 4);
        check("hold_last",    (strobe_q.size() > 0) ? strobe_q[strobe_q.size()-1] - (a + 2) : -1,
              REPEAT_ON ? 28 : 4);
        check("hold_d", d, 4'h6);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 5)      keyboard = mask($urandom_range(0, 9));
            else if (sel < 7) keyboard = 10'($urandom_range(0, 1023));
            else              keyboard = '0;
            if ($urandom_range(0, 9) == 0) enablen = ~enablen;
            clear = ($urandom_range(0, 39) == 0);
            idle($urandom_range(1, 12));
            clear = 1'b0;
        end
        keyboard = '0;
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
